sqr_iter: RTL and testbench

- Sequential shift-add squarer: computes y = x*x for an unsigned WIDTH-bit operand.
- Processes one multiplier bit per clock and holds the result until the next request.
- Inverse companion of the iterative square-root FSM. Used to re-square root results for self-check, and wherever a squared value is needed without a combinational multiplier.
- Same start / result_valid handshake style as the other FSM arithmetic blocks.

---
 rtl/sqr_iter.sv | 111 +++++++++++
 tb/tb_sqr_iter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqr_iter.sv
// Iterative shift-add squarer: y = x*x for an unsigned WIDTH-bit operand,
// one multiplier bit per clock, start/result_valid handshake.
module sqr_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  output logic               busy,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] y
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
  logic               last;

  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign last     = (cnt_q == '0);
  assign acc_next = acc_q + (mult_q[0] ? mcand_q : '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last)  state_d = DONE;
      DONE:    if (start) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      CALC:    busy         = 1'b1;
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on an accepted start, otherwise one add/shift step per CALC cycle.
  always_comb begin
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    if (accept) begin
      mcand_d = {{WIDTH{1'b0}}, x};
      mult_d  = x;
      acc_d   = '0;
      cnt_d   = CW'(WIDTH - 1);
    end else if (state_q == CALC) begin
      acc_d   = acc_next;
      mcand_d = mcand_q << 1;
      mult_d  = mult_q >> 1;
      if (last) begin
        y_d = acc_next;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_sqr_iter.sv
// Scoreboard bench for sqr_iter: stimulus pushes expected squares and
// completion cycles; per-width monitors pop and compare on result_valid rise.
module tb_sqr_iter;

  typedef struct {
    logic [31:0] y;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8_s, start16_s;
  logic [7:0]  x8;
  logic [15:0] x16;
  logic        busy8, rv8, busy16, rv16;
  logic [15:0] y8;
  logic [31:0] y16;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q16[$];

  sqr_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8_s), .x(x8),
    .busy(busy8), .result_valid(rv8), .y(y8)
  );

  sqr_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16_s), .x(x16),
    .busy(busy16), .result_valid(rv16), .y(y16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the 8-bit instance
  logic [15:0] model8 = '0;
  logic        rv8_prev = 1'b0, busy8_prev = 1'b0;
  int          run8 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q8.delete();
      model8 = '0; run8 = 0; rv8_prev = 1'b0; busy8_prev = 1'b0;
    end else begin
      if (rv8 && !rv8_prev) begin
        if (q8.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w8_unexpected_result: got y=%0d, expected no result", y8);
        end else begin
          e = q8.pop_front();
          model8 = e.y[15:0];
          check("w8_latency", cyc, e.cyc);
        end
      end
      check("w8_busy_rv_excl", {63'd0, busy8 & rv8}, 64'd0);
      if (busy8) run8++;
      else if (busy8_prev) begin
        check("w8_busy_len", run8, 8);
        run8 = 0;
      end
      rv8_prev = rv8; busy8_prev = busy8;
    end
    check("w8_y", y8, model8);
  end

  // Monitor for the 16-bit instance
  logic [31:0] model16 = '0;
  logic        rv16_prev = 1'b0, busy16_prev = 1'b0;
  int          run16 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q16.delete();
      model16 = '0; run16 = 0; rv16_prev = 1'b0; busy16_prev = 1'b0;
    end else begin
      if (rv16 && !rv16_prev) begin
        if (q16.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL w16_unexpected_result: got y=%0d, expected no result", y16);
        end else begin
          e = q16.pop_front();
          model16 = e.y;
          check("w16_latency", cyc, e.cyc);
        end
      end
      check("w16_busy_rv_excl", {63'd0, busy16 & rv16}, 64'd0);
      if (busy16) run16++;
      else if (busy16_prev) begin
        check("w16_busy_len", run16, 16);
        run16 = 0;
      end
      rv16_prev = rv16; busy16_prev = busy16;
    end
    check("w16_y", y16, model16);
  end

  // Called at a negedge with the DUT in IDLE or DONE; accepted on the next edge.
  task automatic start8(input logic [7:0] xv, input logic [15:0] yv);
    start8_s = 1'b1;
    x8       = xv;
    q8.push_back('{y: {16'd0, yv}, cyc: cyc + 1 + 8});
    @(negedge clk);
    start8_s = 1'b0;
  endtask

  task automatic start16(input logic [15:0] xv, input logic [31:0] yv);
    start16_s = 1'b1;
    x16       = xv;
    q16.push_back('{y: yv, cyc: cyc + 1 + 16});
    @(negedge clk);
    start16_s = 1'b0;
  endtask

  task automatic wait_done8();
    logic ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rv8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("w8_done_in_time", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_done16();
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rv16) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("w16_done_in_time", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    rst = 1'b0; start8_s = 1'b0; start16_s = 1'b0; x8 = '0; x16 = '0;
    #1;
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_rv8", {63'd0, rv8}, 64'd0);
    check("rst_y8", y8, 0);
    check("rst_y16", y16, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors, each from IDLE/DONE with full latency
    start8(8'd0, 16'd0);       wait_done8();
    start8(8'd13, 16'd169);    wait_done8();
    start8(8'd255, 16'd65025); wait_done8();
    start8(8'd1, 16'd1);       wait_done8();

    // start and x activity during CALC must be ignored
    start8(8'd200, 16'd40000);
    for (int i = 0; i < 6; i++) begin
      start8_s = 1'b1;
      x8 = i[0] ? 8'd252 : 8'd3;
      @(negedge clk);
    end
    start8_s = 1'b0;
    wait_done8();

    // Restart directly from DONE: result_valid drops, y holds old value
    start8(8'd13, 16'd169); wait_done8();
    start8(8'd16, 16'd256);
    check("done_restart_rv", {63'd0, rv8}, 64'd0);
    check("done_restart_busy", {63'd0, busy8}, 64'd1);
    check("done_restart_y_hold", y8, 169);
    wait_done8();

    // Asynchronous reset in the middle of a computation
    start8(8'd255, 16'd65025);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy8}, 64'd0);
    check("midrst_rv", {63'd0, rv8}, 64'd0);
    check("midrst_y", y8, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start8(8'd7, 16'd49); wait_done8();

    // Exhaustive back-to-back sweep from DONE
    for (int i = 0; i < 256; i++) begin
      start8(i[7:0], 16'(i * i));
      wait_done8();
    end

    // 16-bit instance: directed corners plus a random subset
    start16(16'd0, 32'd0);                  wait_done16();
    start16(16'd65535, 32'd4294836225);     wait_done16();
    start16(16'd300, 32'd90000);            wait_done16();
    start16(16'd1234, 32'd1522756);         wait_done16();
    start16(16'd40000, 32'd1600000000);     wait_done16();
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      start16(v, 32'(v) * 32'(v));
      wait_done16();
    end

    repeat (3) @(negedge clk);
    check("w8_queue_drained", q8.size(), 0);
    check("w16_queue_drained", q16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
